// File: rtl/uart_pkg.sv
// uart_pkg: receiver/transmitter state encoding and frame constants shared by the UART blocks
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: parameterized double-flop synchronizer for asynchronous inputs, resets to all ones
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk)
    if (rst) {q, meta} <= '1;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 oversampling receiver with valid/ready output, framing error and overrun pulses
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_serial,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  if (CLKS_PER_BIT < 4) begin : g_bad_param
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end
  logic                      rx_s;
  uart_state_t               state;
  logic [CW-1:0]             cnt;
  logic [2:0]                idx;
  logic [UART_DATA_BITS-1:0] sh;
  sync_2ff #(.W(1)) u_sync (.clk(clk), .rst(rst), .d(rx_serial), .q(rx_s));
  always_ff @(posedge clk)
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START:
          if (cnt == HALF) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else cnt <= cnt + 1'b1;
        DATA:
          if (cnt == LAST) begin
            sh[idx] <= rx_s;
            cnt     <= '0;
            idx     <= idx + 1'b1;
            if (idx == 3'd7) state <= STOP;
          end else cnt <= cnt + 1'b1;
        STOP:
          if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
            // a replacement under a simultaneous handshake keeps rx_valid high
            if (!rx_s) frame_err <= 1'b1;
            else if (!rx_valid || rx_ready) begin
              rx_data  <= sh;
              rx_valid <= 1'b1;
            end else overrun <= 1'b1;
          end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule
